// File: rtl/uart_tx_queue_if.sv
// ---------------------------------------------------------------------------
// uart_tx_queue_if -- bundle of the byte-producer and UART-transmitter signals
// of uart_tx_queue.
//
// Parameter
//   DEPTH                   queue depth; sets the width of Fifo_Count
//
// Signals
//   Wr_Valid                producer offers Wr_Byte this cycle
//   Wr_Byte[7:0]            byte to enqueue
//   Wr_Ready                queue not full
//   Tx_newTransmissionData  one-cycle start strobe to the transmitter
//   Tx_TransmissionByte     byte presented with the strobe, held until the next
//   Tx_active               transmitter busy
//   Tx_done                 transmitter one-cycle byte-complete pulse
//   Fifo_Count              number of occupied queue entries
//   Overflow                sticky "a write was dropped" flag
//
// Modports
//   slave   the queue itself
//   master  the environment (producer plus transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Wr_Valid;
    logic [7:0]    Wr_Byte;
    logic          Wr_Ready;
    logic          Tx_newTransmissionData;
    logic [7:0]    Tx_TransmissionByte;
    logic          Tx_active;
    logic          Tx_done;
    logic [CW-1:0] Fifo_Count;
    logic          Overflow;

    modport slave (
        input  Wr_Valid, Wr_Byte, Tx_active, Tx_done,
        output Wr_Ready, Tx_newTransmissionData, Tx_TransmissionByte,
               Fifo_Count, Overflow
    );

    modport master (
        output Wr_Valid, Wr_Byte, Tx_active, Tx_done,
        input  Wr_Ready, Tx_newTransmissionData, Tx_TransmissionByte,
               Fifo_Count, Overflow
    );
endinterface

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue -- byte FIFO in front of a UART transmitter.
//
// Bytes written by a producer are queued and handed one at a time to the
// transmitter with a one-cycle start strobe; the next byte is offered only
// after the transmitter reports completion (and, optionally, after a fixed
// number of idle bit-times).
//
// Parameters
//   DEPTH         FIFO entries, power of two in 4..64
//   CLKS_PER_BIT  clocks per UART bit
//   GAP_BITS      idle bit-times between bytes (only with UART_TXQ_GAP_EN)
//
// Ports
//   Clock         rising-edge clock
//   Reset         synchronous, active-high reset
//   bus           uart_tx_queue_if.slave (producer and transmitter signals)
//
// Configuration macro
//   UART_TXQ_GAP_EN  when defined, a GAP state holds off the next byte for
//                    GAP_BITS*CLKS_PER_BIT clocks after Tx_done; when not
//                    defined the GAP state and its counter do not exist.
// ---------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 87,
    parameter int GAP_BITS     = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    uart_tx_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Parameter sanity, evaluated at elaboration only.
    if ((DEPTH < 32'sd4) || (DEPTH > 32'sd64) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
        $error("uart_tx_queue: DEPTH must be a power of two from 4 to 64");
    end
    if ((GAP_BITS < 32'sd0) || (CLKS_PER_BIT < 32'sd1) || ((GAP_BITS * CLKS_PER_BIT) > 32'sd65535)) begin : g_bad_gap
        $error("uart_tx_queue: GAP_BITS*CLKS_PER_BIT must lie in 0..65535");
    end

`ifdef UART_TXQ_GAP_EN
    localparam logic [15:0] GAP_LOAD = 16'(GAP_BITS * CLKS_PER_BIT);
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
`ifdef UART_TXQ_GAP_EN
        , GAP     = 2'd3
`endif
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic          strobe_r;
    logic [7:0]    byte_r;
    logic          overflow_r;
`ifdef UART_TXQ_GAP_EN
    logic [15:0]   gap_cnt_r;
`endif

    logic full_s;
    logic wr_en_s;
    logic rd_en_s;

    // Fullness comes from the registered count only, so a read on the same
    // edge never opens room for a write.
    assign full_s  = (count_r == CW'(DEPTH));
    assign wr_en_s = bus.Wr_Valid && !full_s;
    // LOAD is only entered with a non-empty queue, and writes cannot empty
    // it, so every LOAD cycle pops exactly one byte.
    assign rd_en_s = (state_r == LOAD);

    assign bus.Wr_Ready               = !full_s;
    assign bus.Fifo_Count             = count_r;
    assign bus.Tx_newTransmissionData = strobe_r;
    assign bus.Tx_TransmissionByte    = byte_r;
    assign bus.Overflow               = overflow_r;

    // Next-state logic of the hand-off sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if ((count_r != {CW{1'b0}}) && !bus.Tx_active) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                state_nxt_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.Tx_done) begin
`ifdef UART_TXQ_GAP_EN
                    // A zero-length gap would leave GAP with nothing to count.
                    if (GAP_LOAD != 16'd0) begin
                        state_nxt_s = GAP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
`else
                    state_nxt_s = IDLE;
`endif
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
`ifdef UART_TXQ_GAP_EN
            GAP: begin
                // Leave on the edge that takes the counter to zero, so GAP
                // lasts exactly GAP_LOAD cycles.
                if (gap_cnt_r <= 16'd1) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FIFO storage; not reset, and a write in the reset cycle is discarded.
    always_ff @(posedge Clock) begin
        if (wr_en_s && !Reset) begin
            mem_r[wr_ptr_r] <= bus.Wr_Byte;
        end
    end

    // Pointers, occupancy, state register and registered transmitter outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            state_r    <= IDLE;
            strobe_r   <= 1'b0;
            byte_r     <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            strobe_r <= rd_en_s;

            // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                byte_r   <= mem_r[rd_ptr_r];
            end

            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase

            if (bus.Wr_Valid && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef UART_TXQ_GAP_EN
    // Inter-byte gap counter, armed by the Tx_done that ends WAIT_DONE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            gap_cnt_r <= 16'd0;
        end else if ((state_r == WAIT_DONE) && bus.Tx_done) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r == GAP) && (gap_cnt_r != 16'd0)) begin
            gap_cnt_r <= gap_cnt_r - 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue -- self-checking bench for uart_tx_queue.
//
// dut16 (DEPTH=16, default timing) runs directed scenarios: single byte
// latency, inter-byte spacing, fill/overflow/ordering, read-vs-write on a
// full queue, and reset while a byte is in flight.  dut4 (DEPTH=4) carries 40
// random bytes under Wr_Ready flow control against a queue-based model with a
// randomly busy transmitter.
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;
    localparam int D16    = 16;
    localparam int CPB16  = 87;
    localparam int GB16   = 2;
    localparam int D4     = 4;
    localparam int CPB4   = 3;
    localparam int GB4    = 2;
    localparam int BUDGET = 500;
`ifdef UART_TXQ_GAP_EN
    localparam int GAP16  = GB16 * CPB16;
`else
    localparam int GAP16  = 0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   strobe_n;
    logic prev_strobe;

    uart_tx_queue_if #(.DEPTH(D16)) bus16 ();
    uart_tx_queue_if #(.DEPTH(D4))  bus4 ();

    uart_tx_queue #(.DEPTH(D16), .CLKS_PER_BIT(CPB16), .GAP_BITS(GB16)) dut16 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus16)
    );

    uart_tx_queue #(.DEPTH(D4), .CLKS_PER_BIT(CPB4), .GAP_BITS(GB4)) dut4 (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One clock, then sample; also tracks the dut16 strobe and its width.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus16.Tx_newTransmissionData === 1'b1) begin
            check_val("strobe_one_cycle", 32'(prev_strobe), 32'd0);
            strobe_n++;
        end
        prev_strobe = bus16.Tx_newTransmissionData;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write16(input logic [7:0] b);
        bus16.Wr_Valid = 1'b1;
        bus16.Wr_Byte  = b;
        tick();
        bus16.Wr_Valid = 1'b0;
    endtask

    // Transmitter model: busy for two cycles, then a done pulse.
    task automatic tx_serve();
        bus16.Tx_active = 1'b1;
        tick();
        tick();
        bus16.Tx_active = 1'b0;
        bus16.Tx_done   = 1'b1;
        tick();
        bus16.Tx_done   = 1'b0;
    endtask

    task automatic wait_strobe(output int k);
        k = 0;
        while ((bus16.Tx_newTransmissionData !== 1'b1) && (k < BUDGET)) begin
            tick();
            k++;
        end
        check_val("strobe_within_budget", 32'(k < BUDGET), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_count"},  32'(bus16.Fifo_Count), 32'd0);
        check_val({tag, "_ready"},  32'(bus16.Wr_Ready), 32'd1);
        check_val({tag, "_strobe"}, 32'(bus16.Tx_newTransmissionData), 32'd0);
        check_val({tag, "_byte"},   32'(bus16.Tx_TransmissionByte), 32'd0);
        check_val({tag, "_ovf"},    32'(bus16.Overflow), 32'd0);
    endtask

    // Random traffic through dut4 against a queue model.
    task automatic run_rand4();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [7:0] want;
        int sent   = 0;
        int recv   = 0;
        int busy   = 0;
        int mcount = 0;
        bit acc    = 1'b0;
        bit strb;
        for (int cyc = 0; (cyc < 4000) && (recv < 40); cyc++) begin
            @(posedge clk);
            #1;
            strb   = (bus4.Tx_newTransmissionData === 1'b1);
            mcount = mcount + (acc ? 1 : 0) - (strb ? 1 : 0);
            check_val("r4_count", 32'(bus4.Fifo_Count), 32'(mcount));
            check_val("r4_ready", 32'(bus4.Wr_Ready), 32'(mcount < D4));
            // transmitter model
            bus4.Tx_done = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    bus4.Tx_active = 1'b0;
                    bus4.Tx_done   = 1'b1;
                end
            end
            if (strb) begin
                if (exp_q.size() == 0) begin
                    check_val("r4_spurious_strobe", 32'd1, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    check_val("r4_byte", 32'(bus4.Tx_TransmissionByte), 32'(want));
                end
                recv++;
                busy = $urandom_range(1, 6);
                bus4.Tx_active = 1'b1;
            end
            // producer: offer a byte only when the model says there is room
            bus4.Wr_Valid = 1'b0;
            acc = 1'b0;
            if ((sent < 40) && (mcount < D4) && ($urandom_range(0, 3) != 0)) begin
                b = 8'($urandom);
                bus4.Wr_Valid = 1'b1;
                bus4.Wr_Byte  = b;
                exp_q.push_back(b);
                sent++;
                acc = 1'b1;
            end
        end
        bus4.Wr_Valid = 1'b0;
        check_val("r4_sent", 32'(sent), 32'd40);
        check_val("r4_recv", 32'(recv), 32'd40);
        check_val("r4_overflow", 32'(bus4.Overflow), 32'd0);
    endtask

    initial begin
        int k;
        int n0;
        total = 0;
        bad = 0;
        strobe_n = 0;
        prev_strobe = 1'b0;
        rst = 1'b1;
        bus16.Wr_Valid = 1'b0; bus16.Wr_Byte = 8'h00; bus16.Tx_active = 1'b0; bus16.Tx_done = 1'b0;
        bus4.Wr_Valid  = 1'b0; bus4.Wr_Byte  = 8'h00; bus4.Tx_active  = 1'b0; bus4.Tx_done  = 1'b0;

        // single byte: strobe after edge N+2
        do_reset();
        check_reset_state("rst");
        write16(8'h41);
        check_val("t1_count_n", 32'(bus16.Fifo_Count), 32'd1);
        check_val("t1_strobe_n", 32'(bus16.Tx_newTransmissionData), 32'd0);
        tick();
        check_val("t1_strobe_n1", 32'(bus16.Tx_newTransmissionData), 32'd0);
        tick();
        check_val("t1_strobe_n2", 32'(bus16.Tx_newTransmissionData), 32'd1);
        check_val("t1_byte", 32'(bus16.Tx_TransmissionByte), 32'h41);
        check_val("t1_count_n2", 32'(bus16.Fifo_Count), 32'd0);
        tx_serve();
        check_val("t1_byte_held", 32'(bus16.Tx_TransmissionByte), 32'h41);

        // two bytes: second strobe spacing after Tx_done
        do_reset();
        write16(8'hA1);
        write16(8'hA2);
        check_val("t2_count2", 32'(bus16.Fifo_Count), 32'd2);
        tick();
        check_val("t2_first_byte", 32'(bus16.Tx_TransmissionByte), 32'hA1);
        check_val("t2_count1", 32'(bus16.Fifo_Count), 32'd1);
        tx_serve();
        wait_strobe(k);
        check_val("t2_gap_delay", 32'(k), 32'(GAP16 + 2));
        check_val("t2_second_byte", 32'(bus16.Tx_TransmissionByte), 32'hA2);

        // fill with transmitter stalled, overflow, read vs write when full
        do_reset();
        bus16.Tx_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            write16(8'(i));
        end
        check_val("t3_full_count", 32'(bus16.Fifo_Count), 32'd16);
        check_val("t3_full_ready", 32'(bus16.Wr_Ready), 32'd0);
        check_val("t3_no_ovf_yet", 32'(bus16.Overflow), 32'd0);
        write16(8'h10);
        check_val("t3_ovf", 32'(bus16.Overflow), 32'd1);
        check_val("t3_ovf_count", 32'(bus16.Fifo_Count), 32'd16);
        bus16.Tx_active = 1'b0;
        bus16.Wr_Valid  = 1'b1;
        bus16.Wr_Byte   = 8'h11;
        tick();
        check_val("t3_idle_to_load_count", 32'(bus16.Fifo_Count), 32'd16);
        tick();
        bus16.Wr_Valid = 1'b0;
        check_val("t3_load_strobe", 32'(bus16.Tx_newTransmissionData), 32'd1);
        check_val("t3_load_count", 32'(bus16.Fifo_Count), 32'd15);
        check_val("t3_load_ovf", 32'(bus16.Overflow), 32'd1);
        check_val("t3_byte0", 32'(bus16.Tx_TransmissionByte), 32'h00);
        for (int j = 1; j < 16; j++) begin
            tx_serve();
            wait_strobe(k);
            check_val("t3_spacing", 32'(k), 32'(GAP16 + 2));
            check_val("t3_order", 32'(bus16.Tx_TransmissionByte), 32'(j));
        end
        tx_serve();
        n0 = strobe_n;
        repeat (GAP16 + 10) tick();
        check_val("t3_no_extra_bytes", 32'(strobe_n), 32'(n0));
        check_val("t3_empty", 32'(bus16.Fifo_Count), 32'd0);
        check_val("t3_ovf_sticky", 32'(bus16.Overflow), 32'd1);

        // reset while waiting for Tx_done with bytes queued
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write16(8'(8'h50 + i));
            if (bus16.Tx_newTransmissionData === 1'b1) bus16.Tx_active = 1'b1;
        end
        check_val("t4_queued", 32'(bus16.Fifo_Count), 32'd5);
        check_val("t4_busy", 32'(bus16.Tx_active), 32'd1);
        do_reset();
        check_reset_state("t4_rst");
        n0 = strobe_n;
        bus16.Tx_done = 1'b1;
        tick();
        bus16.Tx_done = 1'b0;
        repeat (5) tick();
        write16(8'h66);
        repeat (10) tick();
        check_val("t4_no_strobe_busy", 32'(strobe_n), 32'(n0));
        check_val("t4_count_held", 32'(bus16.Fifo_Count), 32'd1);
        bus16.Tx_active = 1'b0;
        wait_strobe(k);
        check_val("t4_release_latency", 32'(k), 32'd2);
        check_val("t4_byte", 32'(bus16.Tx_TransmissionByte), 32'h66);
        check_val("t4_count_after", 32'(bus16.Fifo_Count), 32'd0);

        // random flow-controlled traffic through DEPTH=4
        do_reset();
        run_rand4();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
